fbuf_stream_writer: RTL
=======================

// Module: fbuf_stream_writer
// PURPOSE
//  Upstream producer for the framebuffer scan-out stage. Accepts an AXI4-Stream video
//  frame and writes it into the framebuffer BRAM write port.
//  The BRAM is double-buffered; the displayed bank is swapped only at the scan-out eof edge.
//  The scan-out stage adds rd_base to its pixel address, so it always reads a complete frame.
// PARAMETERS
//  FRAME_WIDTH      640  displayed width in pixels
//  FRAME_HEIGHT     480  displayed height in pixels
//  SCALING_FACTOR   2    upscale factor; stored image is IMG_W=FRAME_WIDTH/SF x IMG_H=FRAME_HEIGHT/SF
//  FBUF_ADDR_WIDTH  19   BRAM address width; elaboration error if 2*IMG_W*IMG_H > 2**FBUF_ADDR_WIDTH
//  PIXEL_WIDTH      12   stored pixel width (RGB444)
// PORTS
//  clk            in   1       pixel/system clock
//  rst_n          in   1       reset, asynchronous, active-low
//  s_axis_tdata   in   PIXEL_WIDTH  pixel data
//  s_axis_tvalid  in   1       beat valid
//  s_axis_tready  out  1       beat accepted when tvalid&tready
//  s_axis_tuser   in   1       start of frame (first pixel)
//  s_axis_tlast   in   1       end of line (last pixel of row)
//  eof            in   1       scan-out vertical-blank level
//  wr_en          out  1       BRAM write enable
//  wr_addr        out  FBUF_ADDR_WIDTH  BRAM write address
//  wr_data        out  PIXEL_WIDTH  BRAM write data
//  rd_base        out  FBUF_ADDR_WIDTH  base address of displayed bank (0 or IMG_W*IMG_H)
//  frame_swap     out  1       1-cycle pulse on bank swap
//  err_line       out  1       sticky: tlast position mismatch
//  err_sof        out  1       sticky: tuser seen mid-frame
// BEHAVIOUR
//  Reset (async assert, sync release) clears all registers.
//   Outputs: tready=0, wr_en=0, wr_addr=0, wr_data=0, frame_swap=0, err_*=0.
//   Internal: wr_bank=0, rd_bank=1, so rd_base=IMG_W*IMG_H; state=WAIT_SOF.
//  Counters x (0..IMG_W-1) and y (0..IMG_H-1) drive the write offset.
//   The offset is kept incrementally (no multiplier): addr = wr_bank*IMG_W*IMG_H + y*IMG_W + x.
//  Write pipeline: an accepted beat appears on wr_en/wr_addr/wr_data on the next cycle (latency 1).
//   wr_en=0 on cycles with no accepted beat.
//  State WAIT_SOF: tready=1.
//   Beats with tuser=0 are consumed and discarded.
//   A beat with tuser=1 is written at offset 0; then x=1, y=0, go WRITE.
//  State WRITE: tready=1; each accepted beat is written, then x++.
//   At x=IMG_W-1 with tlast=1: x=0, y++.
//   tlast=1 at x<IMG_W-1: set err_line; the rest of the row stays unwritten; x=0, y++.
//   x=IMG_W-1 with tlast=0: write the beat, set err_line, go DROP_LINE.
//   tuser=1 mid-frame: set err_sof; write that beat at offset 0 of the same bank; x=1, y=0.
//   Accepting the beat at x=IMG_W-1, y=IMG_H-1 goes to DONE.
//    This applies regardless of tlast; a missing tlast also sets err_line.
//  State DROP_LINE: tready=1, no writes.
//   On the beat with tlast=1: x=0, y++; go WRITE, or DONE if the row was the last.
//   A tuser beat restarts the frame as in WRITE.
//  State DONE: tready=0 (back-pressure), waiting for a swap.
//  eof rising edge: eof is registered, and the edge is eof & ~eof_q.
//   In DONE: swap rd_bank<=wr_bank and wr_bank<=~wr_bank; pulse frame_swap; go WAIT_SOF.
//   The rd_base change is visible the cycle after the edge.
//   In any other state: no swap; the display repeats the old frame.
//  An eof edge in the same cycle as the final beat is accepted does not swap.
//   The swap waits for the next eof edge.
//  err_line and err_sof clear only on reset.
// TESTING
//  Use FRAME_WIDTH=8, FRAME_HEIGHT=4, SF=1, so IMG=32 and rd_base toggles 32<->0.
//  1 Reset: rst_n low mid-frame -> all outputs 0 and rd_base=32 immediately, no clock needed.
//    Then a full frame of 32 beats (data=index), then an eof pulse ->
//    writes at addr 0..31, frame_swap pulse, rd_base=0.
//  2 Garbage before sof: 5 beats with tuser=0, then a frame -> first write is addr 0 with the sof data.
//  3 Short row: tlast on the 5th beat of row 1 ->
//    err_line=1; the next beat is written at addr 16; the frame still completes.
//  4 Restart: tuser on beat 20 -> err_sof=1; that beat is written at addr 0; 31 more beats reach DONE.
//  5 Late eof: an eof edge during row 2 -> no swap.
//    Complete the frame -> tready=0 until the next eof edge, then swap.
//    The next frame writes addr 32..63.
//  6 Back-pressure and gaps: random tvalid gaps ->
//    wr_en count equals the accepted beat count; wr_addr is strictly sequential.

Source files
------------

// File: rtl/fbuf_stream_writer_if.sv
// rtl/fbuf_stream_writer_if.sv - pixel stream handshake bundle (tdata/tvalid/tready/tuser/tlast)
`timescale 1ns/1ps
interface fbuf_stream_writer_if #(
  parameter int PIXEL_WIDTH = 12
);
  logic [PIXEL_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/fbuf_stream_writer.sv
// rtl/fbuf_stream_writer.sv - video stream to double-buffered framebuffer BRAM writer
`timescale 1ns/1ps
module fbuf_stream_writer #(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int SCALING_FACTOR  = 2,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int PIXEL_WIDTH     = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fbuf_stream_writer_if.slave        s_axis,
  input  logic                       eof,
  output logic                       wr_en,
  output logic [FBUF_ADDR_WIDTH-1:0] wr_addr,
  output logic [PIXEL_WIDTH-1:0]     wr_data,
  output logic [FBUF_ADDR_WIDTH-1:0] rd_base,
  output logic                       frame_swap,
  output logic                       err_line,
  output logic                       err_sof
);
  localparam int AW       = FBUF_ADDR_WIDTH;
  localparam int IMG_W    = FRAME_WIDTH / SCALING_FACTOR;
  localparam int IMG_H    = FRAME_HEIGHT / SCALING_FACTOR;
  localparam int IMG_SIZE = IMG_W * IMG_H;
  localparam int XW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [AW-1:0] IMG_SIZE_A = AW'(IMG_SIZE);
  localparam logic [AW-1:0] IMG_W_A    = AW'(IMG_W);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H - 1);

  // Both banks must fit in the BRAM address space.
  if ((2 * IMG_SIZE) > (2 ** FBUF_ADDR_WIDTH)) begin : g_size_check
    $error("fbuf_stream_writer: two image banks do not fit in FBUF_ADDR_WIDTH");
  end

  typedef enum logic [1:0] {S_WAIT_SOF, S_WRITE, S_DROP_LINE, S_DONE} state_t;

  state_t          state, state_n;
  logic [XW-1:0]   x, x_n;
  logic [YW-1:0]   y, y_n;
  logic [AW-1:0]   off, off_n;        // y*IMG_W + x, kept incrementally
  logic [AW-1:0]   row_base, row_n;   // y*IMG_W
  logic            wr_bank, rd_bank, eof_q, tready_q;
  logic            accept, eof_edge, x_last, y_last;
  logic            do_wr, wr_zero, set_line, set_sof, swap, restart, next_row;
  logic [AW-1:0]   bank_base;

  assign accept        = s_axis.tvalid & tready_q;
  assign eof_edge      = eof & ~eof_q;
  assign x_last        = (x == X_LAST);
  assign y_last        = (y == Y_LAST);
  assign bank_base     = wr_bank ? IMG_SIZE_A : '0;
  assign rd_base       = rd_bank ? IMG_SIZE_A : '0;
  assign s_axis.tready = tready_q;

  // Next-state and counter update; restart/next_row are applied after the case.
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    off_n    = off;
    row_n    = row_base;
    do_wr    = 1'b0;
    wr_zero  = 1'b0;
    set_line = 1'b0;
    set_sof  = 1'b0;
    swap     = 1'b0;
    restart  = 1'b0;
    next_row = 1'b0;
    case (state)
      S_WAIT_SOF: begin
        if (accept && s_axis.tuser) begin
          do_wr   = 1'b1;
          restart = 1'b1;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          do_wr = 1'b1;
          if (s_axis.tuser) begin
            set_sof = 1'b1;
            restart = 1'b1;
          end else if (x_last) begin
            set_line = ~s_axis.tlast;
            if (y_last) state_n = S_DONE;
            else if (s_axis.tlast) next_row = 1'b1;
            else state_n = S_DROP_LINE;
          end else if (s_axis.tlast) begin
            // Short row: the remainder of the row is left unwritten.
            set_line = 1'b1;
            if (y_last) state_n = S_DONE;
            else next_row = 1'b1;
          end else begin
            x_n   = x + XW'(1);
            off_n = off + AW'(1);
          end
        end
      end
      S_DROP_LINE: begin
        if (accept) begin
          if (s_axis.tuser) begin
            do_wr   = 1'b1;
            set_sof = 1'b1;
            restart = 1'b1;
            state_n = S_WRITE;
          end else if (s_axis.tlast) begin
            if (y_last) state_n = S_DONE;
            else begin
              next_row = 1'b1;
              state_n  = S_WRITE;
            end
          end
        end
      end
      S_DONE: begin
        if (eof_edge) begin
          swap    = 1'b1;
          state_n = S_WAIT_SOF;
        end
      end
      default: state_n = S_WAIT_SOF;
    endcase
    if (restart) begin
      wr_zero = 1'b1;
      x_n     = XW'(1);
      y_n     = '0;
      off_n   = AW'(1);
      row_n   = '0;
    end
    if (next_row) begin
      x_n   = '0;
      y_n   = y + YW'(1);
      row_n = row_base + IMG_W_A;
      off_n = row_base + IMG_W_A;
    end
  end

  // FSM state, position counters and the back-pressure flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT_SOF;
      x        <= '0;
      y        <= '0;
      off      <= '0;
      row_base <= '0;
      eof_q    <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state    <= state_n;
      x        <= x_n;
      y        <= y_n;
      off      <= off_n;
      row_base <= row_n;
      eof_q    <= eof;
      tready_q <= (state_n != S_DONE);
    end
  end

  // One-cycle write pipeline into the BRAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= do_wr;
      if (do_wr) begin
        wr_addr <= bank_base + (wr_zero ? '0 : off);
        wr_data <= s_axis.tdata;
      end
    end
  end

  // Bank swap on eof edge once a frame is complete; sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      frame_swap <= 1'b0;
      err_line   <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      frame_swap <= swap;
      if (swap) begin
        rd_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
      err_line <= err_line | set_line;
      err_sof  <= err_sof | set_sof;
    end
  end
endmodule
